// File: rtl/uart_rx_buf_ctrl.sv
// rtl/uart_rx_buf_ctrl.sv - receive-side FWFT buffer controller for a UART
//
// Purpose: captures every byte (plus its frame/parity error flag) strobed by
// uart_rx into a first-word-fall-through FIFO, and exposes it to the bus side
// together with a level threshold interrupt, a sticky overflow flag, a
// saturating error counter and an optional idle-timeout interrupt.
//
// Optional feature macro: UART_RX_BUF_TIMEOUT_EN (idle-timeout interrupt).
// When undefined, timeout_irq_o is tied low and timeout_i is ignored.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   enable_i             block enable; low flushes and clears all state
//   flush_i              pulse: empty the FIFO (wins over push and pop)
//   stat_clr_i           pulse: clear overflow_o and err_cnt_o
//   drop_err_i           discard bytes that arrive with rx_err_i set
//   rx_rdata_i           received byte from uart_rx
//   rx_rvalid_i          one-cycle byte-received strobe
//   rx_err_i             error flag, qualified by rx_rvalid_i
//   pop_i                consume the head entry
//   rdata_o, rerr_o      head byte and its error flag (0 when empty)
//   rvalid_o             FIFO not empty
//   level_o              entries held, 0..DEPTH
//   thresh_i             level threshold (0 disables thresh_irq_o)
//   thresh_irq_o         level_o >= thresh_i, level-sensitive
//   overflow_o           sticky: a byte was lost because the FIFO was full
//   err_cnt_o            saturating count of received error events
//   timeout_i            idle timeout in clock cycles (0 disables)
//   timeout_irq_o        data waiting and idle for timeout_i cycles
module uart_rx_buf_ctrl #(
  parameter  int DEPTH = 8,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          enable_i,
  input  logic          flush_i,
  input  logic          stat_clr_i,
  input  logic          drop_err_i,
  input  logic [7:0]    rx_rdata_i,
  input  logic          rx_rvalid_i,
  input  logic          rx_err_i,
  input  logic          pop_i,
  output logic [7:0]    rdata_o,
  output logic          rerr_o,
  output logic          rvalid_o,
  output logic [LW-1:0] level_o,
  input  logic [LW-1:0] thresh_i,
  output logic          thresh_irq_o,
  output logic          overflow_o,
  output logic [7:0]    err_cnt_o,
  input  logic [15:0]   timeout_i,
  output logic          timeout_irq_o
);

  localparam int PW = $clog2(DEPTH);

  logic [8:0]    mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    err_cnt_q, err_cnt_d;

  logic push, pop_eff, full, err_ev, wr_en, drop;

  always_comb begin
    push    = enable_i & rx_rvalid_i & ~(rx_err_i & drop_err_i);
    pop_eff = pop_i & (count_q != '0);
    full    = (count_q == LW'(DEPTH));
    // Error events are counted whether or not the byte is kept or lost.
    err_ev  = enable_i & rx_rvalid_i & rx_err_i;

    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    err_cnt_d  = err_cnt_q;
    wr_en      = 1'b0;
    drop       = 1'b0;

    if (!enable_i) begin
      wptr_d     = '0;
      rptr_d     = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      err_cnt_d  = '0;
    end else begin
      if (flush_i) begin
        // Flush discards any coincident push and ignores pop.
        wptr_d  = '0;
        rptr_d  = '0;
        count_d = '0;
      end else begin
        // When full, a simultaneous pop frees the slot the push needs.
        wr_en = push & (~full | pop_eff);
        drop  = push & full & ~pop_eff;
        if (wr_en)   wptr_d = wptr_q + 1'b1;
        if (pop_eff) rptr_d = rptr_q + 1'b1;
        unique case ({wr_en, pop_eff})
          2'b10:   count_d = count_q + 1'b1;
          2'b01:   count_d = count_q - 1'b1;
          default: count_d = count_q;
        endcase
      end

      if (drop)            overflow_d = 1'b1;
      else if (stat_clr_i) overflow_d = 1'b0;

      if (stat_clr_i)                          err_cnt_d = {7'd0, err_ev};
      else if (err_ev && err_cnt_q != 8'hFF)   err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wptr_q] <= {rx_err_i, rx_rdata_i};
  end

  assign rvalid_o     = (count_q != '0);
  assign rdata_o      = rvalid_o ? mem_q[rptr_q][7:0] : 8'd0;
  assign rerr_o       = rvalid_o & mem_q[rptr_q][8];
  assign level_o      = count_q;
  assign thresh_irq_o = (thresh_i != '0) && (count_q >= thresh_i);
  assign overflow_o   = overflow_q;
  assign err_cnt_o    = err_cnt_q;

`ifdef UART_RX_BUF_TIMEOUT_EN
  logic [15:0] idle_q, idle_d;

  always_comb begin
    idle_d = idle_q;
    if (!enable_i || push || pop_eff || flush_i || !rvalid_o || timeout_i == 16'd0)
      idle_d = '0;
    // Holds once at or above the limit; lowering timeout_i never re-arms it.
    else if (idle_q < timeout_i)
      idle_d = idle_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) idle_q <= '0;
    else         idle_q <= idle_d;
  end

  assign timeout_irq_o = rvalid_o & (idle_q == timeout_i) & (timeout_i != 16'd0);
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout_i;
  assign timeout_irq_o  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_buf_ctrl.sv
// tb/tb_uart_rx_buf_ctrl.sv - self-checking bench for uart_rx_buf_ctrl
module tb_uart_rx_buf_ctrl;

  localparam int DEPTH = 8;
  localparam int LW    = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          enable_i, flush_i, stat_clr_i, drop_err_i;
  logic [7:0]    rx_rdata_i;
  logic          rx_rvalid_i, rx_err_i, pop_i;
  logic [7:0]    rdata_o;
  logic          rerr_o, rvalid_o;
  logic [LW-1:0] level_o;
  logic [LW-1:0] thresh_i;
  logic          thresh_irq_o, overflow_o;
  logic [7:0]    err_cnt_o;
  logic [15:0]   timeout_i;
  logic          timeout_irq_o;

  uart_rx_buf_ctrl #(.DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .flush_i(flush_i),
    .stat_clr_i(stat_clr_i), .drop_err_i(drop_err_i), .rx_rdata_i(rx_rdata_i),
    .rx_rvalid_i(rx_rvalid_i), .rx_err_i(rx_err_i), .pop_i(pop_i),
    .rdata_o(rdata_o), .rerr_o(rerr_o), .rvalid_o(rvalid_o), .level_o(level_o),
    .thresh_i(thresh_i), .thresh_irq_o(thresh_irq_o), .overflow_o(overflow_o),
    .err_cnt_o(err_cnt_o), .timeout_i(timeout_i), .timeout_irq_o(timeout_irq_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Reference model: a queue of {err, data} entries plus status counters.
  logic [8:0] mq[$];
  int m_ovf = 0, m_ec = 0, m_idle = 0;

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit push, popok, lost, ev, pre_empty;
    if (!enable_i) begin
      mq.delete(); m_ovf = 0; m_ec = 0; m_idle = 0;
      return;
    end
    ev        = rx_rvalid_i & rx_err_i;
    push      = rx_rvalid_i & !(rx_err_i & drop_err_i);
    popok     = pop_i && (mq.size() > 0);
    pre_empty = (mq.size() == 0);
    lost      = 0;
    if (flush_i) mq.delete();
    else begin
      lost = push && (mq.size() == DEPTH) && !popok;
      if (popok) void'(mq.pop_front());
      if (push && !lost) mq.push_back({rx_err_i, rx_rdata_i});
    end
    if (lost) m_ovf = 1; else if (stat_clr_i) m_ovf = 0;
    if (stat_clr_i) m_ec = ev ? 1 : 0;
    else if (ev && m_ec < 255) m_ec++;
    if (push || popok || flush_i || pre_empty || timeout_i == 0) m_idle = 0;
    else if (m_idle < int'(timeout_i)) m_idle++;
  endtask

  task automatic check_model();
    int n;
    logic [8:0] h;
    n = mq.size();
    h = (n > 0) ? mq[0] : 9'd0;
    chk("m_rvalid", rvalid_o, n > 0);
    chk("m_rdata", rdata_o, int'(h[7:0]));
    chk("m_rerr", rerr_o, int'(h[8]));
    chk("m_level", level_o, n);
    chk("m_overflow", overflow_o, m_ovf);
    chk("m_err_cnt", err_cnt_o, m_ec);
    chk("m_thresh_irq", thresh_irq_o, (thresh_i != 0) && (n >= int'(thresh_i)));
`ifdef UART_RX_BUF_TIMEOUT_EN
    chk("m_timeout_irq", timeout_irq_o, (n > 0) && (timeout_i != 0) && (m_idle == int'(timeout_i)));
`else
    chk("m_timeout_irq", timeout_irq_o, 0);
`endif
  endtask

  task automatic cycle();
    @(posedge clk_i);
    model_step();
    #1;
    check_model();
  endtask

  task automatic quiet();
    enable_i = 1'b1; flush_i = 1'b0; stat_clr_i = 1'b0; drop_err_i = 1'b0;
    rx_rvalid_i = 1'b0; rx_err_i = 1'b0; rx_rdata_i = 8'd0; pop_i = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] d);
    quiet(); rx_rvalid_i = 1'b1; rx_rdata_i = d; cycle(); quiet();
  endtask

  typedef struct {
    logic en, fl, clr, drop, rv;
    logic [7:0] d;
    logic err, pop;
    logic [3:0] th;
    logic ev;
    logic [7:0] ed;
    logic ee;
    int el;
    logic eo;
    int ec;
    logic eti;
  } vec_t;

  vec_t vecs[17];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //              en fl clr dr rv d      er pop th | v  data   e lvl o ec ti
    vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,1'b0,1'b0,4'd0, 1'b0,8'h00,1'b0,0,1'b0,0,1'b0};
    vecs[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,8'h55,1'b0,1'b0,4'd0, 1'b1,8'h55,1'b0,1,1'b0,0,1'b0};
    vecs[2]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,8'hA3,1'b0,1'b0,4'd0, 1'b1,8'h55,1'b0,2,1'b0,0,1'b0};
    vecs[3]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,8'h00,1'b0,1'b1,4'd0, 1'b1,8'hA3,1'b0,1,1'b0,0,1'b0};
    vecs[4]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,8'h00,1'b0,1'b1,4'd0, 1'b0,8'h00,1'b0,0,1'b0,0,1'b0};
    vecs[5]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,8'h00,1'b0,1'b1,4'd0, 1'b0,8'h00,1'b0,0,1'b0,0,1'b0};
    vecs[6]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,8'h7E,1'b1,1'b0,4'd0, 1'b1,8'h7E,1'b1,1,1'b0,1,1'b0};
    vecs[7]  = '{1'b1,1'b0,1'b0,1'b1,1'b1,8'h7E,1'b1,1'b0,4'd0, 1'b1,8'h7E,1'b1,1,1'b0,2,1'b0};
    vecs[8]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,8'h11,1'b0,1'b1,4'd3, 1'b1,8'h11,1'b0,1,1'b0,2,1'b0};
    vecs[9]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,8'h22,1'b0,1'b0,4'd3, 1'b1,8'h11,1'b0,2,1'b0,2,1'b0};
    vecs[10] = '{1'b1,1'b0,1'b0,1'b0,1'b1,8'h33,1'b0,1'b0,4'd3, 1'b1,8'h11,1'b0,3,1'b0,2,1'b1};
    vecs[11] = '{1'b1,1'b0,1'b0,1'b0,1'b0,8'h00,1'b0,1'b1,4'd3, 1'b1,8'h22,1'b0,2,1'b0,2,1'b0};
    vecs[12] = '{1'b1,1'b0,1'b0,1'b0,1'b1,8'h44,1'b0,1'b0,4'd0, 1'b1,8'h22,1'b0,3,1'b0,2,1'b0};
    vecs[13] = '{1'b1,1'b0,1'b1,1'b0,1'b0,8'h00,1'b0,1'b0,4'd0, 1'b1,8'h22,1'b0,3,1'b0,0,1'b0};
    vecs[14] = '{1'b1,1'b0,1'b0,1'b0,1'b1,8'h55,1'b0,1'b1,4'd0, 1'b1,8'h33,1'b0,3,1'b0,0,1'b0};
    vecs[15] = '{1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,1'b0,1'b0,4'd0, 1'b0,8'h00,1'b0,0,1'b0,0,1'b0};
    vecs[16] = '{1'b1,1'b0,1'b0,1'b0,1'b1,8'h99,1'b0,1'b1,4'd0, 1'b1,8'h99,1'b0,1,1'b0,0,1'b0};

    rst_ni = 1'b0; quiet(); enable_i = 1'b0; thresh_i = '0; timeout_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_rvalid", rvalid_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_level", level_o, 0);
    chk("rst_overflow", overflow_o, 0);
    chk("rst_err_cnt", err_cnt_o, 0);
    chk("rst_irqs", {thresh_irq_o, timeout_irq_o, rerr_o}, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Table-driven vectors: one row per clock.
    for (int i = 0; i < 17; i++) begin
      enable_i = vecs[i].en; flush_i = vecs[i].fl; stat_clr_i = vecs[i].clr;
      drop_err_i = vecs[i].drop; rx_rvalid_i = vecs[i].rv; rx_rdata_i = vecs[i].d;
      rx_err_i = vecs[i].err; pop_i = vecs[i].pop; thresh_i = vecs[i].th;
      cycle();
      chk($sformatf("v%0d_rvalid", i), rvalid_o, vecs[i].ev);
      chk($sformatf("v%0d_rdata", i), rdata_o, vecs[i].ed);
      chk($sformatf("v%0d_rerr", i), rerr_o, vecs[i].ee);
      chk($sformatf("v%0d_level", i), level_o, vecs[i].el);
      chk($sformatf("v%0d_ovf", i), overflow_o, vecs[i].eo);
      chk($sformatf("v%0d_errcnt", i), err_cnt_o, vecs[i].ec);
      chk($sformatf("v%0d_thirq", i), thresh_irq_o, vecs[i].eti);
    end
    thresh_i = '0;

    // Overflow: 9 pushes into an 8-deep FIFO, then push+pop while full.
    quiet(); enable_i = 1'b0; cycle(); quiet();
    for (int i = 0; i < 9; i++) push_byte(8'h10 + 8'(i));
    chk("full_level", level_o, 8);
    chk("full_ovf", overflow_o, 1);
    rx_rvalid_i = 1'b1; rx_rdata_i = 8'hEE; pop_i = 1'b1; cycle(); quiet();
    chk("full_pushpop_level", level_o, 8);
    chk("full_pushpop_head", rdata_o, 8'h11);
    stat_clr_i = 1'b1; cycle(); quiet();
    chk("ovf_clr", overflow_o, 0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d", i), rdata_o, (i < 7) ? 8'h11 + i : 8'hEE);
      pop_i = 1'b1; cycle(); quiet();
    end
    chk("drain_empty", rvalid_o, 0);

    // Error counter saturation with dropped error bytes.
    quiet(); enable_i = 1'b0; cycle(); quiet();
    for (int i = 0; i < 300; i++) begin
      rx_rvalid_i = 1'b1; rx_err_i = 1'b1; drop_err_i = 1'b1; rx_rdata_i = 8'h7E;
      cycle();
    end
    quiet();
    chk("errcnt_sat", err_cnt_o, 255);
    chk("errcnt_dropped_level", level_o, 0);

    // Flush coincident with push at level 5, with overflow already set.
    for (int i = 0; i < 9; i++) push_byte(8'hA0 + 8'(i));
    for (int i = 0; i < 3; i++) begin pop_i = 1'b1; cycle(); quiet(); end
    chk("pre_flush_level", level_o, 5);
    flush_i = 1'b1; rx_rvalid_i = 1'b1; rx_rdata_i = 8'hCC; cycle(); quiet();
    chk("flush_level", level_o, 0);
    chk("flush_rvalid", rvalid_o, 0);
    chk("flush_ovf_kept", overflow_o, 1);
    chk("flush_errcnt_kept", err_cnt_o, 255);
    push_byte(8'h01); push_byte(8'h02);
    enable_i = 1'b0; cycle(); quiet();
    chk("disable_level", level_o, 0);
    chk("disable_ovf", overflow_o, 0);
    chk("disable_errcnt", err_cnt_o, 0);

`ifdef UART_RX_BUF_TIMEOUT_EN
    // Idle timeout: irq after 20 idle edges following the push.
    timeout_i = 16'd20;
    push_byte(8'h5A);
    for (int k = 1; k <= 25; k++) begin
      cycle();
      chk($sformatf("to_k%0d", k), timeout_irq_o, k >= 20);
    end
    pop_i = 1'b1; cycle(); quiet();
    chk("to_pop_clear", timeout_irq_o, 0);
    timeout_i = 16'd0;
    push_byte(8'h5B);
    for (int k = 0; k < 40; k++) cycle();
    chk("to_disabled", timeout_irq_o, 0);
`endif

    // Randomized phase against the reference model.
    quiet(); enable_i = 1'b0; cycle();
    timeout_i = 16'd7;
    for (int i = 0; i < 4000; i++) begin
      enable_i    = ($urandom_range(99) < 98);
      flush_i     = ($urandom_range(99) < 3);
      stat_clr_i  = ($urandom_range(99) < 5);
      drop_err_i  = $urandom_range(1);
      rx_rvalid_i = ($urandom_range(99) < 45);
      rx_err_i    = ($urandom_range(99) < 20);
      rx_rdata_i  = 8'($urandom);
      pop_i       = ($urandom_range(99) < ((i / 500) % 2 ? 20 : 50));
      thresh_i    = LW'($urandom_range(DEPTH));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_buf_ctrl.md
Name: uart_rx_buf_ctrl

Overview:
Receive-side buffer controller between uart_rx and the UART register/bus interface. Captures each byte that uart_rx signals as received, with its error flag, into a first-word-fall-through FIFO. Also provides:
- pop handshake for the bus side
- fill-level threshold interrupt
- sticky overflow flag
- saturating receive-error counter
- optional idle-timeout interrupt

Parameters:
DEPTH, 8, FIFO entries; power of 2, minimum 2
LW, $clog2(DEPTH)+1, level width (derived; do not override)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active-low
enable_i  in  1  block enable; low = synchronous flush and clear of all state
flush_i  in  1  one-cycle pulse: empty FIFO
stat_clr_i  in  1  pulse: clear overflow_o and err_cnt_o
drop_err_i  in  1  1 = discard bytes received with error
rx_rdata_i  in  8  byte from uart_rx
rx_rvalid_i  in  1  one-cycle byte-received strobe from uart_rx
rx_err_i  in  1  frame/parity error, qualified by rx_rvalid_i
pop_i  in  1  consume head entry
rdata_o  out  8  head byte (FWFT)
rerr_o  out  1  error flag of head entry
rvalid_o  out  1  FIFO not empty
level_o  out  LW  entries held, 0..DEPTH
thresh_i  in  LW  level threshold
thresh_irq_o  out  1  level_o >= thresh_i and thresh_i != 0
overflow_o  out  1  sticky: byte lost because FIFO full
err_cnt_o  out  8  saturating count of rx_err_i events
timeout_i  in  16  idle timeout in clk cycles (0 = disabled)
timeout_irq_o  out  1  data waiting and idle for timeout_i cycles

Behaviour:
- Reset: all outputs 0, pointers 0, FIFO empty.
- enable_i low: same state as reset, applied synchronously.
- Storage: DEPTH x 9 bits (err, data).
  - Write and read pointers are log2(DEPTH) bits and wrap naturally.
  - Occupancy counter is LW bits.
- push = enable_i & rx_rvalid_i & ~(rx_err_i & drop_err_i).
- pop_eff = pop_i & rvalid_o; pop_i while empty is ignored with no side effect.
- Full (level_o == DEPTH):
  - push without pop: byte dropped, overflow_o set next cycle.
  - push with pop: both succeed, level unchanged.
- Empty with push and pop_i in the same cycle: pop ignored, push succeeds (no bypass).
- FWFT: a byte pushed in cycle N appears on rdata_o/rerr_o, and rvalid_o rises, in cycle N+1.
  - pop_i in cycle M: next entry (or rvalid_o=0) presented in M+1.
- level_o, thresh_irq_o: registered/derived from registered occupancy; valid one cycle after the push/pop.
- flush_i beats push and pop in the same cycle:
  - FIFO empties next cycle; the incoming byte is discarded.
  - overflow_o and err_cnt_o are not affected.
- overflow_o: set by a dropped push, cleared by stat_clr_i. Set wins over clear in the same cycle.
- err_cnt_o: +1 on each rx_rvalid_i & rx_err_i, independent of drop_err_i and overflow; saturates at 255.
  - stat_clr_i clears it; a simultaneous error event loads 1.
- thresh_irq_o: level-sensitive, not sticky; drops as soon as level falls below thresh_i.

Optional Feature:
UART_RX_BUF_TIMEOUT_EN
- Defined: 16-bit idle counter.
  - Cleared to 0 on push, pop_eff, flush, empty FIFO, or timeout_i == 0.
  - Otherwise increments each cycle and saturates at timeout_i.
  - timeout_irq_o = rvalid_o & (cnt == timeout_i) & (timeout_i != 0); stays high until a clear condition.
  - Once the irq is high, lowering timeout_i below the saturated count does not re-arm the counter; only a clear condition does.
- Not defined: no counter; timeout_irq_o tied 0; timeout_i unused.

Test Plan:
1. Push 0x55, 0xA3 (err=0) -> rdata_o=0x55 and rvalid_o=1 the cycle after first strobe; level_o=2; pop -> 0xA3 next cycle; second pop -> rvalid_o=0, level_o=0.
2. DEPTH=8: push 9 bytes with no pops -> level_o=8, overflow_o=1, FIFO holds first 8. Then push+pop same cycle -> level_o stays 8; stat_clr_i -> overflow_o=0.
3. rx_err_i=1 byte 0x7E:
   - drop_err_i=0 -> stored, rerr_o=1 at head, err_cnt_o=1.
   - drop_err_i=1 -> not stored, err_cnt_o=2.
   - 300 error strobes -> err_cnt_o=255.
4. thresh_i=3: pushes 1..3 -> thresh_irq_o rises with level_o=3; one pop -> falls; thresh_i=0 -> never asserts.
5. flush_i coincident with push at level 5 -> level_o=0, rvalid_o=0, overflow_o and err_cnt_o unchanged. Deassert enable_i mid-fill -> all cleared.
6. (macro on) timeout_i=20, one push, then idle -> timeout_irq_o asserts 20 cycles after the push and stays high; pop clears it. With timeout_i=0 -> never asserts.
